renkon_conv_tree_acc: RTL and testbench

Parametrised, fully pipelined K×K convolution dot-product unit with a valid-tagged streaming interface. Each beat multiplies TAPS pixel/weight pairs, requantises every product by a per-beat shift with selectable rounding, and reduces the results through a registered adder tree. A channel accumulator sums successive beats between first and last flags, then emits one saturated DWIDTH feature-map value per output pixel. It replaces the fixed 9-tap tree in the renkon conv core and serves 1×1, 3×3 and 5×5 kernels and multi-channel accumulation.

---
 rtl/renkon_pkg.sv | 63 ++++++
 rtl/renkon_add_tree.sv | 98 +++++++++
 rtl/renkon_conv_tree_acc.sv | 178 +++++++++++++++++
 tb/tb_renkon_conv_tree_acc.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/renkon_pkg.sv
// rtl/renkon_pkg.sv - shared widths, sizing helpers and product requantiser for renkon datapaths
package renkon_pkg;

    localparam int DWIDTH_DEF = 16;
    localparam int LWIDTH_DEF = 5;

    // Working width for requantisation; covers 2*DWIDTH products plus rounding bias
    localparam int QW = 64;

    // Control bundle bit positions travelling alongside the data
    localparam int CTL_W = 3;
    localparam int CTL_V = 2;
    localparam int CTL_F = 1;
    localparam int CTL_L = 0;

    typedef struct packed {
        logic signed [QW-1:0] val;
        logic                 clip;
    } quant_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Number of nodes left after lvl pairwise reduction levels starting from n
    function automatic int node_cnt(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
        return c;
    endfunction

    // Right-shift a product by qbits (floor or round-half-up) and clip to dw signed bits
    function automatic quant_t quantise(input logic signed [QW-1:0] pro,
                                        input logic [7:0]           qbits,
                                        input logic                 rnd,
                                        input int                   dw);
        quant_t               r;
        logic signed [QW-1:0] biased;
        logic signed [QW-1:0] shifted;
        logic signed [QW-1:0] hi;
        logic signed [QW-1:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        biased = pro;
        if (rnd && (qbits != 8'd0)) biased = pro + (64'sd1 <<< (qbits - 8'd1));
        shifted = biased >>> qbits;
        r.val  = shifted;
        r.clip = 1'b0;
        if (shifted > hi) begin
            r.val  = hi;
            r.clip = 1'b1;
        end else if (shifted < lo) begin
            r.val  = lo;
            r.clip = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/renkon_add_tree.sv
// rtl/renkon_add_tree.sv - registered pairwise adder tree with clip-flag OR-tree and sideband
module renkon_add_tree
    import renkon_pkg::*;
#(
    parameter int N  = 9,
    parameter int W  = 32,
    parameter int SW = 3
) (
    input  logic                clk,
    input  logic                xrst,
    input  logic signed [W-1:0] in_data [N],
    input  logic [N-1:0]        in_flag,
    input  logic [SW-1:0]       in_side,
    output logic signed [W-1:0] out_data,
    output logic                out_flag,
    output logic [SW-1:0]       out_side
);

    localparam int L = clog2(N);

    logic signed [W-1:0] d    [1:L][N];
    logic                f    [1:L][N];
    logic [SW-1:0]       side [1:L];

    for (genvar l = 0; l < L; l++) begin : g_lvl
        localparam int NI = node_cnt(N, l);
        localparam int NO = node_cnt(N, l + 1);

        for (genvar j = 0; j < NO; j++) begin : g_node
            if (2 * j + 1 < NI) begin : g_pair
                logic signed [W-1:0] a;
                logic signed [W-1:0] b;
                logic                fa;
                logic                fb;
                if (l == 0) begin : g_src_in
                    assign a  = in_data[2*j];
                    assign b  = in_data[2*j+1];
                    assign fa = in_flag[2*j];
                    assign fb = in_flag[2*j+1];
                end else begin : g_src_reg
                    assign a  = d[l][2*j];
                    assign b  = d[l][2*j+1];
                    assign fa = f[l][2*j];
                    assign fb = f[l][2*j+1];
                end
                // Sum a pair of nodes and merge their clip flags
                always_ff @(posedge clk or negedge xrst) begin
                    if (!xrst) begin
                        d[l+1][j] <= '0;
                        f[l+1][j] <= 1'b0;
                    end else begin
                        d[l+1][j] <= a + b;
                        f[l+1][j] <= fa | fb;
                    end
                end
            end else begin : g_odd
                logic signed [W-1:0] a;
                logic                fa;
                if (l == 0) begin : g_src_in
                    assign a  = in_data[2*j];
                    assign fa = in_flag[2*j];
                end else begin : g_src_reg
                    assign a  = d[l][2*j];
                    assign fa = f[l][2*j];
                end
                // Odd leftover node is delayed one level to stay aligned
                always_ff @(posedge clk or negedge xrst) begin
                    if (!xrst) begin
                        d[l+1][j] <= '0;
                        f[l+1][j] <= 1'b0;
                    end else begin
                        d[l+1][j] <= a;
                        f[l+1][j] <= fa;
                    end
                end
            end
        end

        if (l == 0) begin : g_side_in
            // Sideband enters the tree alongside level-0 data
            always_ff @(posedge clk or negedge xrst) begin
                if (!xrst) side[1] <= '0;
                else       side[1] <= in_side;
            end
        end else begin : g_side_reg
            // Sideband follows the data one level per cycle
            always_ff @(posedge clk or negedge xrst) begin
                if (!xrst) side[l+1] <= '0;
                else       side[l+1] <= side[l];
            end
        end
    end

    assign out_data = d[L][0];
    assign out_flag = f[L][0];
    assign out_side = side[L];

endmodule

// File: rtl/renkon_conv_tree_acc.sv
// rtl/renkon_conv_tree_acc.sv - pipelined KxK dot product with requantise, adder tree and channel accumulator
module renkon_conv_tree_acc
    import renkon_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int LWIDTH = LWIDTH_DEF,
    parameter int TAPS   = 9,
    parameter int AWIDTH = 32
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic [LWIDTH-1:0]        qbits,
    input  logic                     rnd_mode,
    input  logic [TAPS*DWIDTH-1:0]   pixel,
    input  logic [TAPS*DWIDTH-1:0]   weight,
    output logic                     out_valid,
    output logic signed [DWIDTH-1:0] fmap,
    output logic                     sat
);

    localparam logic signed [AWIDTH-1:0] F_MAX = {{(AWIDTH-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [AWIDTH-1:0] F_MIN = {{(AWIDTH-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

    logic [TAPS*DWIDTH-1:0]     s1_pix;
    logic [TAPS*DWIDTH-1:0]     s1_wgt;
    logic [LWIDTH-1:0]          s1_q;
    logic                       s1_rnd;
    logic [CTL_W-1:0]           s1_ctl;

    logic signed [2*DWIDTH-1:0] s2_pro [TAPS];
    logic [LWIDTH-1:0]          s2_q;
    logic                       s2_rnd;
    logic [CTL_W-1:0]           s2_ctl;

    quant_t                     qr     [TAPS];
    logic signed [DWIDTH-1:0]   s3_val [TAPS];
    logic [TAPS-1:0]            s3_clip;
    logic [CTL_W-1:0]           s3_ctl;

    logic signed [AWIDTH-1:0]   tree_in [TAPS];
    logic signed [AWIDTH-1:0]   tree_sum;
    logic                       tree_flag;
    logic [CTL_W-1:0]           tree_ctl;

    logic signed [AWIDTH-1:0]   acc;
    logic signed [AWIDTH-1:0]   acc_next;
    logic                       sticky;
    logic                       sticky_next;
    logic                       acc_fire;
    logic                       clip_hi;
    logic                       clip_lo;

    // S1: capture the beat and its control
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            s1_pix <= '0;
            s1_wgt <= '0;
            s1_q   <= '0;
            s1_rnd <= 1'b0;
            s1_ctl <= '0;
        end else begin
            s1_pix <= pixel;
            s1_wgt <= weight;
            s1_q   <= qbits;
            s1_rnd <= rnd_mode;
            s1_ctl <= {in_valid, in_first, in_last};
        end
    end

    // S2: full-precision signed products
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < TAPS; i++) s2_pro[i] <= '0;
            s2_q   <= '0;
            s2_rnd <= 1'b0;
            s2_ctl <= '0;
        end else begin
            for (int i = 0; i < TAPS; i++)
                s2_pro[i] <= $signed(s1_pix[i*DWIDTH +: DWIDTH]) * $signed(s1_wgt[i*DWIDTH +: DWIDTH]);
            s2_q   <= s1_q;
            s2_rnd <= s1_rnd;
            s2_ctl <= s1_ctl;
        end
    end

    // Requantise every product with the shift and rounding mode of its own beat
    always_comb begin
        for (int i = 0; i < TAPS; i++)
            qr[i] = quantise(QW'(s2_pro[i]), 8'(s2_q), s2_rnd, DWIDTH);
    end

    // S3: register clipped per-tap values and clip flags
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < TAPS; i++) s3_val[i] <= '0;
            s3_clip <= '0;
            s3_ctl  <= '0;
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                s3_val[i]  <= qr[i].val[DWIDTH-1:0];
                s3_clip[i] <= qr[i].clip;
            end
            s3_ctl <= s2_ctl;
        end
    end

    // Sign-extend the tap values to the tree width
    always_comb begin
        for (int i = 0; i < TAPS; i++) tree_in[i] = AWIDTH'(s3_val[i]);
    end

    renkon_add_tree #(
        .N  (TAPS),
        .W  (AWIDTH),
        .SW (CTL_W)
    ) u_tree (
        .clk      (clk),
        .xrst     (xrst),
        .in_data  (tree_in),
        .in_flag  (s3_clip),
        .in_side  (s3_ctl),
        .out_data (tree_sum),
        .out_flag (tree_flag),
        .out_side (tree_ctl)
    );

    // First beat restarts the channel sum and sticky clip flag, later beats add on
    always_comb begin
        acc_next    = acc + tree_sum;
        sticky_next = sticky | tree_flag;
        if (tree_ctl[CTL_F]) begin
            acc_next    = tree_sum;
            sticky_next = tree_flag;
        end
    end

    // Accumulate stage: only valid beats touch the running sum
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            acc      <= '0;
            sticky   <= 1'b0;
            acc_fire <= 1'b0;
        end else begin
            acc_fire <= tree_ctl[CTL_V] & tree_ctl[CTL_L];
            if (tree_ctl[CTL_V]) begin
                acc    <= acc_next;
                sticky <= sticky_next;
            end
        end
    end

    // Range check of the finished sum against the output width
    always_comb begin
        clip_hi = (acc > F_MAX);
        clip_lo = (acc < F_MIN);
    end

    // Output stage: one-cycle pulse, fmap and sat hold between pulses
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            out_valid <= 1'b0;
            fmap      <= '0;
            sat       <= 1'b0;
        end else begin
            out_valid <= acc_fire;
            if (acc_fire) begin
                if (clip_hi)      fmap <= F_MAX[DWIDTH-1:0];
                else if (clip_lo) fmap <= F_MIN[DWIDTH-1:0];
                else              fmap <= acc[DWIDTH-1:0];
                sat <= sticky | clip_hi | clip_lo;
            end
        end
    end

endmodule

// File: tb/tb_renkon_conv_tree_acc.sv
// tb/tb_renkon_conv_tree_acc.sv - directed self-checking bench for renkon_conv_tree_acc
module tb_renkon_conv_tree_acc;

    localparam int DW   = 16;
    localparam int LW   = 5;
    localparam int TAPS = 9;
    localparam int AW   = 32;

    logic                 clk;
    logic                 xrst;
    logic                 in_valid;
    logic                 in_first;
    logic                 in_last;
    logic [LW-1:0]        qbits;
    logic                 rnd_mode;
    logic [TAPS*DW-1:0]   pixel;
    logic [TAPS*DW-1:0]   weight;
    logic                 out_valid;
    logic signed [DW-1:0] fmap;
    logic                 sat;

    typedef struct {
        int                   cyc;
        logic signed [DW-1:0] f;
        logic                 s;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_pass = 0;

    renkon_conv_tree_acc #(
        .DWIDTH (DW),
        .LWIDTH (LW),
        .TAPS   (TAPS),
        .AWIDTH (AW)
    ) dut (
        .clk       (clk),
        .xrst      (xrst),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .qbits     (qbits),
        .rnd_mode  (rnd_mode),
        .pixel     (pixel),
        .weight    (weight),
        .out_valid (out_valid),
        .fmap      (fmap),
        .sat       (sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) evq.push_back(ev_t'{cyc, fmap, sat});
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_pulse(input string tag, input int ecyc, input int ef, input int es);
        ev_t e;
        n_chk++;
        assert (evq.size() > 0) n_pass++;
        else $error("FAIL %s_present: observed 0 pulses expected 1", tag);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            chk({tag, "_cyc"}, e.cyc, ecyc);
            chk({tag, "_fmap"}, e.f, ef);
            chk({tag, "_sat"}, e.s, es);
        end
    endtask

    task automatic set_all(input int p, input int w);
        for (int i = 0; i < TAPS; i++) begin
            pixel[i*DW +: DW]  = 16'(p);
            weight[i*DW +: DW] = 16'(w);
        end
    endtask

    task automatic set_tap0(input int p, input int w);
        pixel  = '0;
        weight = '0;
        pixel[DW-1:0]  = 16'(p);
        weight[DW-1:0] = 16'(w);
    endtask

    task automatic beat(input logic f, input logic l, input int q, input logic r, output int bc);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        qbits    = 5'(q);
        rnd_mode = r;
        bc       = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int b0;
        int bx;
        int bs [3];
        int rb [6];
        int rp [6] = '{3, 3, -3, -3, -5, -5};
        int rw [6] = '{1, 1, 1, 1, 3, 3};
        int rq [6] = '{1, 1, 1, 1, 0, 0};
        int rr [6] = '{0, 1, 0, 1, 0, 1};
        int re [6] = '{1, 2, -2, -1, -15, -15};

        xrst = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        qbits = '0; rnd_mode = 1'b0; pixel = '0; weight = '0;
        idle(3);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fmap", $signed(fmap), 0);
        chk("rst_sat", sat, 0);
        xrst = 1'b1;
        idle(2);

        // single beat, latency 9
        set_all(256, 256);
        beat(1, 1, 8, 0, b0);
        idle(12);
        chk_pulse("single", b0 + 9, 2304, 0);
        chk("single_extra", evq.size(), 0);

        // three consecutive channel beats
        beat(1, 0, 8, 0, b0);
        beat(0, 0, 8, 0, bx);
        beat(0, 1, 8, 0, bx);
        idle(14);
        chk_pulse("acc3", b0 + 11, 6912, 0);
        chk("acc3_extra", evq.size(), 0);

        // same accumulation with 2-cycle gaps; stale flags in gaps are ignored
        beat(1, 0, 8, 0, b0);
        idle(2);
        beat(0, 0, 8, 0, bx);
        in_first = 1'b1; in_last = 1'b1;
        idle(2);
        beat(0, 1, 8, 0, bx);
        idle(14);
        chk_pulse("acc3gap", b0 + 15, 6912, 0);
        chk("acc3gap_extra", evq.size(), 0);

        // rounding cases, back-to-back single-beat pixels
        for (int k = 0; k < 6; k++) begin
            set_tap0(rp[k], rw[k]);
            beat(1, 1, rq[k], rr[k][0], rb[k]);
        end
        idle(14);
        for (int k = 0; k < 6; k++)
            chk_pulse($sformatf("round%0d", k), rb[k] + 9, re[k], 0);
        chk("round_extra", evq.size(), 0);

        // saturation high, low, then a clean beat clears sat
        set_all(32767, 32767);
        beat(1, 1, 0, 0, bs[0]);
        set_all(32767, -32767);
        beat(1, 1, 0, 0, bs[1]);
        set_all(256, 256);
        beat(1, 1, 8, 0, bs[2]);
        idle(14);
        chk_pulse("sat_hi", bs[0] + 9, 32767, 1);
        chk_pulse("sat_lo", bs[1] + 9, -32768, 1);
        chk_pulse("sat_clr", bs[2] + 9, 2304, 0);

        // asynchronous reset in the middle of an accumulation
        beat(1, 0, 8, 0, b0);
        beat(0, 0, 8, 0, bx);
        beat(0, 1, 8, 0, bx);
        idle(1);
        #2 xrst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_fmap", $signed(fmap), 0);
        chk("arst_sat", sat, 0);
        idle(3);
        xrst = 1'b1;
        idle(20);
        chk("arst_no_output", evq.size(), 0);

        // fresh beat after reset release
        set_all(100, -3);
        beat(1, 1, 2, 0, b0);
        idle(12);
        chk_pulse("fresh", b0 + 9, -675, 0);
        chk("fresh_extra", evq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
